rt_lim_line_seq: RTL

Clocked, parametrised racetrack logic-in-memory line with an integrated shift/access sequencer. It holds an NB-bit data track and an NB-bit mask track, accessed through NP equally spaced ports, and performs whole-word write, read and bitwise logic-in-memory (LIM) operations with optional write-back. It sits between the LIM memory controller and the racetrack array, replacing the pulse-driven single line. The sequencer itself generates the shift pulses, tracks domain position, chooses shift direction, and counts shifts for energy accounting.

---
 rtl/rt_lim_line_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rt_lim_line_seq.sv
// Racetrack logic-in-memory line: NB-bit data and mask tracks, NP equally spaced access ports,
// and a sequencer that sweeps all NSP positions per op, generating shift pulses itself.
module rt_lim_line_seq #(
  parameter int NB  = 32,
  parameter int NP  = 8,
  parameter int NSP = NB / NP,
  parameter int PW  = (NSP > 1) ? $clog2(NSP) : 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_i,
  input  logic [1:0]    op_i,
  input  logic [1:0]    mode_i,
  input  logic          wb_i,
  input  logic [NB-1:0] wdata_i,
  output logic          ready_o,
  output logic          done_o,
  output logic [NB-1:0] rdata_o,
  output logic [PW-1:0] pos_o,
  output logic          shift_o,
  output logic          shift_dir_o,
  output logic [CW-1:0] shift_cnt_o
);

  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [PW-1:0] LAST_STEP = PW'(NSP - 1);
  localparam logic          MULTI_POS = (NSP > 1) ? 1'b1 : 1'b0;

  localparam logic [1:0] OP_WRITE_DATA = 2'b00;
  localparam logic [1:0] OP_WRITE_MASK = 2'b01;
  localparam logic [1:0] OP_READ       = 2'b10;
  localparam logic [1:0] OP_LIM        = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_r;
  logic [1:0]    op_r;
  logic [1:0]    mode_r;
  logic          wb_r;
  logic [NB-1:0] wdata_r;
  logic [NB-1:0] data_r;
  logic [NB-1:0] mask_r;
  logic [NB-1:0] rdata_r;
  logic [NB-1:0] rdata_acc_r;
  logic [PW-1:0] pos_r;
  logic [PW-1:0] step_r;
  logic          dir_r;
  logic          shift_r;
  logic          done_r;
  logic          ready_r;
  logic [CW-1:0] shift_cnt_r;

  logic [NB-1:0] data_nxt_s;
  logic [NB-1:0] mask_nxt_s;
  logic [NB-1:0] rdata_nxt_s;
  logic [BW-1:0] bit_idx_s;
  logic          lim_bit_s;

  function automatic logic lim_f(input logic d, input logic m, input logic [1:0] mode);
    case (mode)
      2'b00:   lim_f = ~(d & m);
      2'b01:   lim_f = ~(d | m);
      2'b10:   lim_f = d & m;
      2'b11:   lim_f = d | m;
      default: lim_f = 1'b0;
    endcase
  endfunction

  // Per-port access at the current position: next track contents and result accumulator.
  always_comb begin
    data_nxt_s  = data_r;
    mask_nxt_s  = mask_r;
    rdata_nxt_s = rdata_acc_r;
    bit_idx_s   = {BW{1'b0}};
    lim_bit_s   = 1'b0;
    for (int k = 0; k < NP; k++) begin
      bit_idx_s = BW'(k * NSP) + BW'(pos_r);
      case (op_r)
        OP_WRITE_DATA: data_nxt_s[bit_idx_s] = wdata_r[bit_idx_s];
        OP_WRITE_MASK: mask_nxt_s[bit_idx_s] = wdata_r[bit_idx_s];
        OP_READ:       rdata_nxt_s[bit_idx_s] = data_r[bit_idx_s];
        OP_LIM: begin
          lim_bit_s = lim_f(data_r[bit_idx_s], mask_r[bit_idx_s], mode_r);
          rdata_nxt_s[bit_idx_s] = lim_bit_s;
          if (wb_r) begin
            data_nxt_s[bit_idx_s] = lim_bit_s;
          end else begin
            data_nxt_s[bit_idx_s] = data_r[bit_idx_s];
          end
        end
        default: data_nxt_s = data_r;
      endcase
    end
  end

  // Sequencer FSM, tracks and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      op_r        <= 2'b00;
      mode_r      <= 2'b00;
      wb_r        <= 1'b0;
      wdata_r     <= {NB{1'b0}};
      data_r      <= {NB{1'b0}};
      mask_r      <= {NB{1'b0}};
      rdata_r     <= {NB{1'b0}};
      rdata_acc_r <= {NB{1'b0}};
      pos_r       <= {PW{1'b0}};
      step_r      <= {PW{1'b0}};
      dir_r       <= 1'b1;
      shift_r     <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      shift_cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (req_i) begin
            op_r        <= op_i;
            mode_r      <= mode_i;
            wb_r        <= wb_i;
            wdata_r     <= wdata_i;
            // Only an op starting at position 0 sweeps upward; anything else sweeps down.
            dir_r       <= (pos_r == {PW{1'b0}});
            step_r      <= {PW{1'b0}};
            rdata_acc_r <= {NB{1'b0}};
            shift_r     <= MULTI_POS;
            ready_r     <= 1'b0;
            state_r     <= ST_ACCESS;
          end else begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          data_r      <= data_nxt_s;
          mask_r      <= mask_nxt_s;
          rdata_acc_r <= rdata_nxt_s;
          if (step_r == LAST_STEP) begin
            shift_r <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
            if (op_r == OP_READ || op_r == OP_LIM) begin
              rdata_r <= rdata_nxt_s;
            end else begin
              rdata_r <= rdata_r;
            end
          end else begin
            step_r <= step_r + PW'(1);
            if (dir_r) begin
              pos_r <= pos_r + PW'(1);
            end else begin
              pos_r <= pos_r - PW'(1);
            end
            // shift_o is registered one cycle ahead so it coincides with the cycle that shifts.
            shift_r <= ((step_r + PW'(1)) != LAST_STEP);
            if (shift_cnt_r != {CW{1'b1}}) begin
              shift_cnt_r <= shift_cnt_r + CW'(1);
            end else begin
              shift_cnt_r <= shift_cnt_r;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          shift_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o     = ready_r;
  assign done_o      = done_r;
  assign rdata_o     = rdata_r;
  assign pos_o       = pos_r;
  assign shift_o     = shift_r;
  assign shift_dir_o = dir_r;
  assign shift_cnt_o = shift_cnt_r;

endmodule
